// File: rtl/conv_line_feeder_if.sv
// Handshake bundle between a pixel source, the line feeder and the conv stage.
// Carries the input pixel handshake, the output column handshake and framing flags.
interface conv_line_feeder_if #(
  parameter int BIT_WIDTH = 8
);
  logic [6*BIT_WIDTH-1:0]  in_pix;
  logic                    in_valid;
  logic                    in_ready;
  logic [30*BIT_WIDTH-1:0] out_col;
  logic                    out_valid;
  logic                    out_ready;
  logic                    col_first;
  logic                    win_valid;
  logic                    frame_done;

  modport master (
    output in_pix, in_valid, out_ready,
    input  in_ready, out_col, out_valid,
    input  col_first, win_valid, frame_done
  );

  modport slave (
    input  in_pix, in_valid, out_ready,
    output in_ready, out_col, out_valid,
    output col_first, win_valid, frame_done
  );
endinterface

// File: rtl/conv_line_feeder.sv
// Line feeder for the 5x5x6 conv: keeps 4 rows per channel, emits 5-pixel columns.
// Ports: clk, rst (async high), bus (slave side), frame_cnt when FEEDER_FRAME_CNT_EN.
module conv_line_feeder #(
  parameter int BIT_WIDTH = 8,
  parameter int IMG_W     = 14,
  parameter int IMG_H     = 14
) (
  input  logic clk,
  input  logic rst,
  conv_line_feeder_if.slave bus
`ifdef FEEDER_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);
  localparam int NCH = 6;
  localparam int NLB = 4;
  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);

  typedef enum logic {FILL, STREAM} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           col;
  logic [RW-1:0]           row;
  logic                    acc, emit, load;
  logic                    row_end, frame_end;
  logic                    last_q;
  logic [30*BIT_WIDTH-1:0] col_nxt;
  logic [BIT_WIDTH-1:0]    lb [NCH][NLB][IMG_W];

  assign emit      = bus.out_valid & bus.out_ready;
  assign bus.in_ready = !rst & (!bus.out_valid | bus.out_ready);
  assign acc       = bus.in_valid & bus.in_ready;
  assign row_end   = col == CW'(IMG_W - 1);
  assign frame_end = row_end & (row == RW'(IMG_H - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL:
        if (acc && row_end && row == RW'(NLB - 1))
          state_nxt = STREAM;
      STREAM:
        if (acc && frame_end)
          state_nxt = FILL;
    endcase
  end

  always_comb begin
    load = acc & (state == STREAM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (acc) begin
      if (row_end) begin
        col <= '0;
        row <= frame_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // lb0 holds the oldest row; each accept pushes the column up by one row.
  always_ff @(posedge clk) begin
    if (acc) begin
      for (int k = 0; k < NCH; k++) begin
        lb[k][0][col] <= lb[k][1][col];
        lb[k][1][col] <= lb[k][2][col];
        lb[k][2][col] <= lb[k][3][col];
        lb[k][3][col] <= bus.in_pix[BIT_WIDTH*k +: BIT_WIDTH];
      end
    end
  end

  always_comb begin
    col_nxt = '0;
    for (int k = 0; k < NCH; k++) begin
      for (int j = 0; j < NLB; j++)
        col_nxt[BIT_WIDTH*(5*k+j) +: BIT_WIDTH] = lb[k][j][col];
      col_nxt[BIT_WIDTH*(5*k+4) +: BIT_WIDTH] =
        bus.in_pix[BIT_WIDTH*k +: BIT_WIDTH];
    end
  end

  // last_q tags the held column as the frame's final one so that
  // frame_done fires on its emit, however long downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_col    <= '0;
      bus.out_valid  <= 1'b0;
      bus.col_first  <= 1'b0;
      bus.win_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      last_q         <= 1'b0;
    end else begin
      bus.frame_done <= emit & last_q;
      if (load) begin
        bus.out_col   <= col_nxt;
        bus.out_valid <= 1'b1;
        bus.col_first <= col == '0;
        bus.win_valid <= col >= CW'(4);
        last_q        <= frame_end;
      end else if (emit) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

`ifdef FEEDER_FRAME_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 frame_cnt <= '0;
    else if (bus.frame_done) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_conv_line_feeder.sv
// Directed bench for conv_line_feeder: frames, window flags, stalls,
// back-to-back frames, mid-frame reset and random handshakes.
`timescale 1ns/1ps
module tb_conv_line_feeder;
  localparam int BW   = 8;
  localparam int W    = 14;
  localparam int H    = 14;
  localparam int NPIX = W * H;
  localparam int NCOL = (H - 4) * W;

  typedef struct packed {
    logic [30*BW-1:0] col;
    logic             first;
    logic             win;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_line_feeder_if #(.BIT_WIDTH(BW)) bus ();
`ifdef FEEDER_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  conv_line_feeder #(
    .BIT_WIDTH(BW),
    .IMG_W(W),
    .IMG_H(H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FEEDER_FRAME_CNT_EN
    ,
    .frame_cnt(frame_cnt)
`endif
  );

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   first_ov = -1;
  int   acc40 = -1;
  int   bad_idx = -1;
  obs_t q[$];
  int   q_cyc[$];
  int   fd_cyc[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      q.push_back('{bus.out_col, bus.col_first, bus.win_valid});
      q_cyc.push_back(cyc);
    end
    if (bus.out_valid && first_ov < 0) first_ov = cyc;
    if (bus.frame_done) fd_cyc.push_back(cyc);
    if (bus.in_valid && bus.in_ready) n_acc++;
  end

  function automatic logic [BW-1:0] pv(int seed, int r, int c, int k);
    return BW'((r * W + c + k + seed) % 128);
  endfunction

  function automatic logic [6*BW-1:0] pack_pix(int seed, int r, int c);
    logic [6*BW-1:0] p;
    for (int k = 0; k < 6; k++) p[BW*k +: BW] = pv(seed, r, c, k);
    return p;
  endfunction

  function automatic logic [30*BW-1:0] exp_col(int seed, int r, int c);
    logic [30*BW-1:0] e;
    for (int k = 0; k < 6; k++)
      for (int j = 0; j < 5; j++)
        e[BW*(5*k+j) +: BW] = pv(seed, r - 4 + j, c, k);
    return e;
  endfunction

  // Counts columns of one frame in q (from base) that differ from the model.
  function automatic int frame_errs(int seed, int base);
    int n = 0;
    obs_t o;
    bad_idx = -1;
    if (q.size() < base + NCOL) return NCOL;
    for (int i = 0; i < NCOL; i++) begin
      int r = 4 + i / W;
      int c = i % W;
      o = q[base + i];
      if (o.col !== exp_col(seed, r, c) || o.first !== (c == 0) ||
          o.win !== (c >= 4)) begin
        if (bad_idx < 0) bad_idx = i;
        n++;
      end
    end
    return n;
  endfunction

  task automatic clear_obs();
    q.delete();
    q_cyc.delete();
    fd_cyc.delete();
    n_acc = 0;
    first_ov = -1;
    acc40 = -1;
  endtask

  task automatic send_frame(input int seed, input int p0, input int p1,
                            input bit rnd);
    int p = p0;
    int r = p0 / W;
    int c = p0 % W;
    int guard = 0;
    while (p < p1) begin
      bus.in_pix    = pack_pix(seed, r, c);
      bus.in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        if (r == 4 && c == 0) acc40 = cyc;
        p++;
        if (c == W - 1) begin
          c = 0;
          r = (r == H - 1) ? 0 : r + 1;
        end else begin
          c++;
        end
      end
      @(posedge clk); #1;
      guard++;
      if (guard > 20000) begin
        total++;
        bad++;
        $display("FAIL send_timeout got=%0d exp=%0d", p, p1);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_pix = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL rst_in_ready got=%0b exp=0", bus.in_ready);
    end
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_out_valid got=%0b exp=0", bus.out_valid);
    end
    total++;
    if (bus.out_col !== '0) begin
      bad++; $display("FAIL rst_out_col got=%0h exp=0", bus.out_col);
    end
    total++;
    if ({bus.col_first, bus.win_valid, bus.frame_done} !== 3'b000) begin
      bad++;
      $display("FAIL rst_flags got=%0b%0b%0b exp=000",
               bus.col_first, bus.win_valid, bus.frame_done);
    end
`ifdef FEEDER_FRAME_CNT_EN
    total++;
    if (frame_cnt !== 16'd0) begin
      bad++; $display("FAIL rst_frame_cnt got=%0d exp=0", frame_cnt);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL post_rst_in_ready got=%0b exp=1", bus.in_ready);
    end
  endtask

  task automatic test_frame();
    obs_t o;
    int e;
    clear_obs();
    send_frame(0, 0, NPIX, 1'b0);
    drain();
    total++;
    if (first_ov !== acc40 + 1) begin
      bad++;
      $display("FAIL first_out_cycle got=%0d exp=%0d", first_ov, acc40 + 1);
    end
    total++;
    if (q.size() !== NCOL) begin
      bad++; $display("FAIL frame_cols got=%0d exp=%0d", q.size(), NCOL);
    end
    if (q.size() > 0) begin
      o = q[0];
      total++;
      if (o.col[39:0] !== 40'h382A1C0E00) begin
        bad++;
        $display("FAIL col0_ch0 got=%0h exp=382a1c0e00", o.col[39:0]);
      end
      total++;
      if ({o.first, o.win} !== 2'b10) begin
        bad++; $display("FAIL col0_flags got=%0b%0b exp=10", o.first, o.win);
      end
    end
    e = frame_errs(0, 0);
    total++;
    if (e !== 0) begin
      bad++; $display("FAIL frame_data got=%0d bad cols (first %0d) exp=0", e, bad_idx);
    end
    total++;
    if (fd_cyc.size() !== 1) begin
      bad++; $display("FAIL frame_done_count got=%0d exp=1", fd_cyc.size());
    end else if (q_cyc.size() == NCOL) begin
      total++;
      if (fd_cyc[0] !== q_cyc[NCOL-1] + 1) begin
        bad++;
        $display("FAIL frame_done_cycle got=%0d exp=%0d", fd_cyc[0], q_cyc[NCOL-1] + 1);
      end
    end
  endtask

  task automatic test_window();
    obs_t o;
    clear_obs();
    send_frame(0, 0, NPIX, 1'b0);
    drain();
    total++;
    if (q.size() < 15) begin
      bad++; $display("FAIL win_cols got=%0d exp=%0d", q.size(), NCOL);
    end else begin
      o = q[4];
      total++;
      if ({o.first, o.win} !== 2'b01) begin
        bad++; $display("FAIL c4_flags got=%0b%0b exp=01", o.first, o.win);
      end
      total++;
      if (o.col[207:200] !== 8'd9) begin
        bad++; $display("FAIL c4_ch5_j0 got=%0d exp=9", o.col[207:200]);
      end
      total++;
      if (o.col[239:232] !== 8'd65) begin
        bad++; $display("FAIL c4_ch5_j4 got=%0d exp=65", o.col[239:232]);
      end
      o = q[3];
      total++;
      if (o.win !== 1'b0) begin
        bad++; $display("FAIL c3_win got=%0b exp=0", o.win);
      end
      o = q[14];
      total++;
      if ({o.first, o.win} !== 2'b10) begin
        bad++; $display("FAIL r5c0_flags got=%0b%0b exp=10", o.first, o.win);
      end
    end
  endtask

  task automatic test_hold();
    logic [30*BW-1:0] snap;
    logic [1:0]       fsnap;
    int               e;
    clear_obs();
    send_frame(0, 0, 100, 1'b0);
    bus.in_pix    = pack_pix(0, 7, 2);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL hold_pre_valid got=%0b exp=1", bus.out_valid);
    end
    snap  = bus.out_col;
    fsnap = {bus.col_first, bus.win_valid};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus.out_col !== snap || {bus.col_first, bus.win_valid} !== fsnap ||
          bus.out_valid !== 1'b1) begin
        bad++;
        $display("FAIL hold_stable got=%0h exp=%0h", bus.out_col, snap);
      end
      total++;
      if (bus.in_ready !== 1'b0) begin
        bad++; $display("FAIL hold_in_ready got=%0b exp=0", bus.in_ready);
      end
      @(posedge clk); #1;
    end
    send_frame(0, 100, NPIX, 1'b0);
    drain();
    e = frame_errs(0, 0);
    total++;
    if (e !== 0 || q.size() !== NCOL) begin
      bad++;
      $display("FAIL hold_seq got=%0d bad/%0d cols exp=0/%0d", e, q.size(), NCOL);
    end
    total++;
    if (n_acc !== NPIX) begin
      bad++; $display("FAIL hold_accepts got=%0d exp=%0d", n_acc, NPIX);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    int e0;
    int e1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_obs();
    t0 = cyc;
    send_frame(0, 0, NPIX, 1'b0);
    send_frame(0, 0, NPIX, 1'b0);
    total++;
    if (cyc - t0 !== 2 * NPIX) begin
      bad++; $display("FAIL b2b_cycles got=%0d exp=%0d", cyc - t0, 2 * NPIX);
    end
    drain();
    total++;
    if (q.size() !== 2 * NCOL) begin
      bad++; $display("FAIL b2b_cols got=%0d exp=%0d", q.size(), 2 * NCOL);
    end else begin
      total++;
      if (q_cyc[NCOL] - q_cyc[NCOL-1] !== 57) begin
        bad++;
        $display("FAIL b2b_gap got=%0d exp=57", q_cyc[NCOL] - q_cyc[NCOL-1]);
      end
    end
    e0 = frame_errs(0, 0);
    e1 = frame_errs(0, NCOL);
    total++;
    if (e0 !== 0 || e1 !== 0) begin
      bad++; $display("FAIL b2b_data got=%0d/%0d exp=0/0", e0, e1);
    end
    total++;
    if (fd_cyc.size() !== 2) begin
      bad++; $display("FAIL b2b_frame_done got=%0d exp=2", fd_cyc.size());
    end
`ifdef FEEDER_FRAME_CNT_EN
    total++;
    if (frame_cnt !== 16'd2) begin
      bad++; $display("FAIL b2b_frame_cnt got=%0d exp=2", frame_cnt);
    end
`endif
  endtask

  task automatic test_mid_reset();
    int e;
    clear_obs();
    send_frame(0, 0, 101, 1'b0);
    bus.in_pix   = pack_pix(0, 7, 3);
    bus.in_valid = 1'b1;
    total++;
    if (bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL mrst_pre_valid got=%0b exp=1", bus.out_valid);
    end
    rst = 1'b1;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL mrst_drop got=%0b%0b exp=00", bus.out_valid, bus.in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    clear_obs();
    send_frame(7, 0, NPIX, 1'b0);
    drain();
    total++;
    if (first_ov !== acc40 + 1) begin
      bad++;
      $display("FAIL mrst_first_out got=%0d exp=%0d", first_ov, acc40 + 1);
    end
    e = frame_errs(7, 0);
    total++;
    if (e !== 0 || q.size() !== NCOL) begin
      bad++;
      $display("FAIL mrst_data got=%0d bad/%0d cols exp=0/%0d", e, q.size(), NCOL);
    end
  endtask

  task automatic test_random();
    int e;
    for (int f = 0; f < 2; f++) begin
      clear_obs();
      send_frame(3 + 6 * f, 0, NPIX, 1'b1);
      drain();
      total++;
      if (n_acc !== NPIX) begin
        bad++; $display("FAIL rnd_accepts f%0d got=%0d exp=%0d", f, n_acc, NPIX);
      end
      total++;
      if (q.size() !== NCOL) begin
        bad++; $display("FAIL rnd_emits f%0d got=%0d exp=%0d", f, q.size(), NCOL);
      end
      e = frame_errs(3 + 6 * f, 0);
      total++;
      if (e !== 0) begin
        bad++;
        $display("FAIL rnd_data f%0d got=%0d bad (first %0d) exp=0", f, e, bad_idx);
      end
      total++;
      if (fd_cyc.size() !== 1) begin
        bad++; $display("FAIL rnd_frame_done f%0d got=%0d exp=1", f, fd_cyc.size());
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_pix    = '0;
    test_reset();
    test_frame();
    test_window();
    test_hold();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
